// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync,
// checks line/frame geometry against the configured timing and reports lock and errors.
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_ce,
  input  logic       i_hsync,
  input  logic       i_vsync,
  output logic       o_locked,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  output logic       o_err,
  output logic [2:0] o_err_code,
  output logic [7:0] o_err_cnt
);

  localparam logic [9:0] HStart   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HEnd     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VStart   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VEnd     = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncW   = 10'(H_SYNC);
  localparam logic [9:0] VSyncW   = 10'(V_SYNC);
  localparam logic [9:0] CntMax   = 10'd1023;
  localparam logic [9:0] CntNear  = 10'd1022;
  localparam logic [3:0] LockGood = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_in_q, vs_in_q, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  hcnt_q, hcnt_d, hwidth_q, hwidth_d, vcnt_q, vcnt_d, vwidth_q, vwidth_d;
  logic        vs_pend_q, vs_pend_d;
  logic [3:0]  good_q, good_d;
  logic        locked_q, locked_d, active_q, active_d, fs_q, fs_d, err_q, err_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;

  logic hs_fall, hs_rise, vs_fall, vs_rise, frame_start;
  logic err_line, err_hsw, err_frame, any_err, h_in, v_in;

  // Edges are between consecutive pixel samples, not consecutive clocks.
  assign hs_fall     = i_pix_ce & hs_prev_q & ~hs_in_q;
  assign hs_rise     = i_pix_ce & ~hs_prev_q & hs_in_q;
  assign vs_fall     = i_pix_ce & vs_prev_q & ~vs_in_q;
  assign vs_rise     = i_pix_ce & ~vs_prev_q & vs_in_q;
  assign frame_start = hs_fall & vs_pend_q;

  always_comb begin
    state_d   = state_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    hcnt_d    = hcnt_q;
    hwidth_d  = hwidth_q;
    vcnt_d    = vcnt_q;
    vwidth_d  = vwidth_q;
    vs_pend_d = vs_pend_q;
    good_d    = good_q;
    locked_d  = locked_q;
    active_d  = active_q;
    x_d       = x_q;
    y_d       = y_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    fs_d      = 1'b0;
    err_d     = 1'b0;
    err_line  = 1'b0;
    err_hsw   = 1'b0;
    err_frame = 1'b0;
    any_err   = 1'b0;
    h_in      = 1'b0;
    v_in      = 1'b0;

    if (i_pix_ce) begin
      hs_prev_d = hs_in_q;
      vs_prev_d = vs_in_q;

      if (hs_fall) begin
        err_line = (hcnt_q != HLast);
        hcnt_d   = '0;
      end else if (hcnt_q != CntMax) begin
        hcnt_d   = hcnt_q + 10'd1;
        err_line = (hcnt_q == CntNear);  // lost hsync
      end

      if (hs_fall) begin
        hwidth_d = 10'd1;
      end else if (!hs_in_q && hwidth_q != CntMax) begin
        hwidth_d = hwidth_q + 10'd1;
      end
      if (hs_rise) err_hsw = (hwidth_q != HSyncW);

      // A vsync fall coinciding with an hsync fall arms the *next* hsync fall.
      vs_pend_d = vs_fall | (vs_pend_q & ~hs_fall);
      if (frame_start) begin
        vcnt_d    = '0;
        err_frame = (vcnt_q != VLast);
      end else if (hs_fall && vcnt_q != CntMax) begin
        vcnt_d    = vcnt_q + 10'd1;
        err_frame = (vcnt_q == CntNear);
      end

      if (vs_fall) begin
        vwidth_d = {9'b0, hs_fall};
      end else if (!vs_in_q && hs_fall && vwidth_q != CntMax) begin
        vwidth_d = vwidth_q + 10'd1;
      end
      if (vs_rise) err_frame = err_frame | (vwidth_q != VSyncW);

      any_err = err_line | err_hsw | err_frame;

      case (state_q)
        StSearch: begin
          if (frame_start) begin
            state_d = StVerify;
            good_d  = '0;
          end
        end
        StVerify: begin
          if (any_err) begin
            state_d = StSearch;
          end else if (frame_start) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 >= LockGood) state_d = StLocked;
          end
        end
        StLocked: begin
          if (any_err) state_d = StSearch;
        end
        default: state_d = StSearch;
      endcase

      if (any_err && state_q != StSearch) begin
        err_d  = 1'b1;
        code_d = {err_frame, err_hsw, err_line};
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
      end

      fs_d     = frame_start && (state_d != StSearch);
      locked_d = (state_d == StLocked);
      h_in     = (hcnt_d >= HStart) && (hcnt_d < HEnd);
      v_in     = (vcnt_d >= VStart) && (vcnt_d < VEnd);
      active_d = locked_d && h_in && v_in;
      x_d      = active_d ? hcnt_d - HStart : '0;
      y_d      = active_d ? vcnt_d - VStart : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StSearch;
      hs_in_q   <= 1'b1;
      vs_in_q   <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hcnt_q    <= '0;
      hwidth_q  <= '0;
      vcnt_q    <= '0;
      vwidth_q  <= '0;
      vs_pend_q <= 1'b0;
      good_q    <= '0;
      locked_q  <= 1'b0;
      active_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hs_in_q   <= i_hsync;
      vs_in_q   <= i_vsync;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      hcnt_q    <= hcnt_d;
      hwidth_q  <= hwidth_d;
      vcnt_q    <= vcnt_d;
      vwidth_q  <= vwidth_d;
      vs_pend_q <= vs_pend_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      active_q  <= active_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_active      = active_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = fs_q;
  assign o_err         = err_q;
  assign o_err_code    = code_q;
  assign o_err_cnt     = cnt_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: drives a reduced-size sync stream with random strobe gaps
// and compares against expectations derived from the stream geometry.
module tb_vga_sync_monitor;

  localparam int HA = 8;
  localparam int HS = 4;
  localparam int HB = 2;
  localparam int HT = 20;
  localparam int VA = 6;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = 14;
  localparam int LF = 2;

  localparam int KNom       = 0;
  localparam int KLongLine  = 1;
  localparam int KShortH    = 2;
  localparam int KLongFrame = 3;
  localparam int KWideV     = 4;
  localparam int KLostH     = 5;

  logic       i_clk = 1'b0;
  logic       i_rst, i_pix_ce, i_hsync, i_vsync;
  logic       o_locked, o_active, o_frame_start, o_err;
  logic [9:0] o_x, o_y;
  logic [2:0] o_err_code;
  logic [7:0] o_err_cnt;

  int errors = 0;
  int checks = 0;
  int n = 0;          // clean frame starts since last reported error / reset
  int exp_cnt = 0;
  int exp_code = 0;
  int pend_code = 0;  // frame-length violation seen at the next frame start
  int last_len = HT;
  int cur_l = -1;
  int cur_p = -1;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .LOCK_FRAMES(LF)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pix_ce     (i_pix_ce),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .o_locked     (o_locked),
    .o_active     (o_active),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_frame_start(o_frame_start),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (line %0d px %0d): got %0d expected %0d", tag, cur_l, cur_p, obs, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_locked", o_locked, 0);
    chk("rst_active", o_active, 0);
    chk("rst_x", o_x, 0);
    chk("rst_y", o_y, 0);
    chk("rst_frame_start", o_frame_start, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_code", o_err_code, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n = 0; exp_cnt = 0; exp_code = 0; pend_code = 0; last_len = HT;
    check_zero();
  endtask

  // One pixel: pins set, registered on the next edge, then sampled by a strobe.
  task automatic pix(input logic h, input logic v, input int l, input int p, input int viol,
                     input bit fs);
    bit rep, exp_fs, lk, win;
    int x, y, gap;
    cur_l = l; cur_p = p;
    i_hsync = h; i_vsync = v;
    @(posedge i_clk); #1;
    i_pix_ce = 1'b1;
    @(posedge i_clk); #1;
    i_pix_ce = 1'b0;
    rep = (viol != 0) && (n >= 1);
    if (rep) begin
      n = 0;
      exp_code = viol;
      if (exp_cnt < 255) exp_cnt++;
    end else if (fs) begin
      n++;
    end
    exp_fs = fs && !rep;
    lk     = (n >= LF + 1);
    x      = p - (HS + HB);
    y      = l - 1 - (VS + VB);
    win    = lk && x >= 0 && x < HA && y >= 0 && y < VA;
    chk("locked", o_locked, lk);
    chk("active", o_active, win);
    chk("x", o_x, win ? x : 0);
    chk("y", o_y, win ? y : 0);
    chk("err", o_err, rep);
    chk("err_code", o_err_code, exp_code);
    chk("err_cnt", o_err_cnt, exp_cnt);
    chk("frame_start", o_frame_start, exp_fs);
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      @(posedge i_clk); #1;
      chk("gap_err", o_err, 0);
      chk("gap_frame_start", o_frame_start, 0);
      chk("gap_locked", o_locked, lk);
    end
  endtask

  task automatic frame(input int kind, input int fl, input int rst_line);
    int nlines, len, hsw, vsl, viol;
    bit fs;
    nlines = (kind == KLongFrame) ? VT + 1 : VT;
    vsl    = (kind == KWideV) ? VS + 1 : VS;
    for (int l = 0; l < nlines; l++) begin
      len = (l == fl && kind == KLongLine) ? HT + 1 : (l == fl && kind == KLostH) ? 1030 : HT;
      hsw = (l == fl && kind == KShortH) ? HS - 1 : HS;
      for (int p = 0; p < len; p++) begin
        if (l == rst_line && p == HS + 3) do_reset();
        viol = 0;
        fs   = (l == 1 && p == 0);
        if (p == 0) begin
          if (last_len != HT) viol |= 1;
          if (fs) begin
            viol |= pend_code;
            pend_code = 0;
          end
          if (kind == KWideV && l == vsl) viol |= 4;
        end
        if (p == hsw && hsw != HS) viol |= 2;
        if (kind == KLostH && l == fl && p == 1023) viol |= 1;
        pix(p >= hsw, l >= vsl, l, p, viol, fs);
      end
      last_len = len;
    end
    if (kind == KLongFrame) pend_code = 4;
  endtask

  initial begin
    i_rst = 1'b1; i_pix_ce = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check_zero();

    repeat (4) frame(KNom, -1, -1);
    for (int k = KLongLine; k <= KLostH; k++) begin
      frame(k, $urandom_range(2, VT - 3), -1);
      repeat (4) frame(KNom, -1, -1);
    end
    frame(KNom, -1, $urandom_range(3, VT - 2));
    repeat (4) frame(KNom, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
